// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - byte FIFO draining into an 8N1 UART serializer
// Optional even-parity bit between data and stop when UART_TX_PARITY_EN is defined.
module uart_tx_fifo #(
  parameter int CLK_FREQ = 70000000,
  parameter int BAUD     = 9600,
  parameter int DEPTH    = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       wr_en,
  input  logic [7:0]                 wr_data,
  output logic                       full,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       overflow,
  output logic                       busy,
  output logic                       tx
);

  localparam int DIV = CLK_FREQ / BAUD;
  localparam int DW  = $clog2(DIV);
  localparam int AW  = $clog2(DEPTH);
  localparam int CW  = $clog2(DEPTH + 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
`ifdef UART_TX_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif
  localparam logic [2:0] STOP   = 3'd4;

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [2:0]    state;
  logic [DW-1:0] baud_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift;
  logic          push;
  logic          pop;
  logic          baud_done;
`ifdef UART_TX_PARITY_EN
  logic          parity_bit;
`endif

  // full comes from the registered count, so a push is judged before any same-edge pop
  assign full      = (count == CW'(DEPTH));
  assign busy      = (state != IDLE) || (count != '0);
  assign push      = wr_en && !full;
  assign pop       = (state == IDLE) && (count != '0);
  assign baud_done = (baud_cnt == DW'(DIV - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (wr_en && full) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx       <= 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_bit <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          tx       <= 1'b1;
          baud_cnt <= '0;
          if (pop) begin
            shift <= mem[rd_ptr];
`ifdef UART_TX_PARITY_EN
            parity_bit <= ^mem[rd_ptr];
`endif
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            state    <= DATA;
            tx       <= shift[0];
          end else begin
            baud_cnt <= baud_cnt + DW'(1);
          end
        end
        DATA: begin
          if (baud_done) begin
            baud_cnt <= '0;
            if (bit_idx == 3'd7) begin
`ifdef UART_TX_PARITY_EN
              state <= PARITY;
              tx    <= parity_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= shift >> 1;
              tx      <= shift[1];
            end
          end else begin
            baud_cnt <= baud_cnt + DW'(1);
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= STOP;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + DW'(1);
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud_cnt <= '0;
            state    <= IDLE;
            tx       <= 1'b1;
          end else begin
            baud_cnt <= baud_cnt + DW'(1);
          end
        end
        default: begin
          state    <= IDLE;
          baud_cnt <= '0;
          tx       <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb/tb_uart_tx_fifo.sv - scoreboard bench for uart_tx_fifo with a timeline reference model
module tb_uart_tx_fifo;
  localparam int DIV   = 16;
  localparam int DEPTH = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif
  localparam int FRAME = NBITS * DIV;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       full, overflow, busy, tx;
  logic [2:0] count;

  uart_tx_fifo #(.CLK_FREQ(16), .BAUD(1), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .count(count), .overflow(overflow), .busy(busy), .tx(tx)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Model: every accepted byte gets an accept edge and a predicted start edge
  int         acc_edge[$];
  int         start_edge[$];
  logic [7:0] exp_byte[$];
  int         exp_start[$];
  int         ovf_edge = -1;

  function automatic int occ_upto(input int e, input bit inclusive);
    int n = 0;
    foreach (acc_edge[i])   if (inclusive ? acc_edge[i] <= e : acc_edge[i] < e) n++;
    foreach (start_edge[i]) if (inclusive ? start_edge[i] <= e : start_edge[i] < e) n--;
    return n;
  endfunction

  function automatic bit model_busy(input int e);
    bit b = (occ_upto(e, 1'b1) != 0);
    foreach (start_edge[i]) if (start_edge[i] <= e && e < start_edge[i] + FRAME) b = 1'b1;
    return b;
  endfunction

  task automatic model_clear();
    acc_edge.delete(); start_edge.delete(); exp_byte.delete(); exp_start.delete();
    ovf_edge = -1;
  endtask

  task automatic push(input logic [7:0] b, output int e);
    int s;
    @(negedge clk);
    e = cyc + 1;
    wr_en = 1'b1;
    wr_data = b;
    if (occ_upto(e, 1'b0) < DEPTH) begin
      s = e + 1;
      if (start_edge.size() > 0 && start_edge[$] + FRAME + 1 > s) s = start_edge[$] + FRAME + 1;
      acc_edge.push_back(e);
      start_edge.push_back(s);
      exp_byte.push_back(b);
      exp_start.push_back(s);
    end else if (ovf_edge < 0) begin
      ovf_edge = e;
    end
  endtask

  task automatic gap(input int n);
    @(negedge clk);
    wr_en = 1'b0;
    repeat (n - 1) @(negedge clk);
  endtask

  bit chk_en = 1'b0;
  always @(negedge clk) if (chk_en) begin
    check("count", count, occ_upto(cyc, 1'b1));
    check("full", full, occ_upto(cyc, 1'b1) == DEPTH);
    check("busy", busy, model_busy(cyc));
    check("overflow", overflow, ovf_edge >= 0 && ovf_edge <= cyc);
  end

  // Monitor: decode frames from tx mid-bit and compare against the scoreboard
  bit         mon_en = 1'b0;
  bit         mon_act = 1'b0;
  int         mon_start;
  int         frames_seen = 0;
  logic [7:0] cur_b;
  logic [7:0] rx;
  always @(negedge clk) if (mon_en) begin
    if (!mon_act) begin
      if (tx === 1'b0) begin
        mon_act = 1'b1;
        mon_start = cyc;
        rx = 8'h00;
        frames_seen++;
        check("frame_expected", exp_byte.size() > 0, 1);
        if (exp_byte.size() > 0) begin
          cur_b = exp_byte.pop_front();
          check("start_edge", cyc, exp_start.pop_front());
        end else begin
          cur_b = 8'hxx;
        end
      end
    end else if ((cyc - mon_start) % DIV == DIV / 2) begin
      int k;
      k = (cyc - mon_start) / DIV;
      if (k == 0) check("start_bit", tx, 0);
      else if (k <= 8) rx[k-1] = tx;
      else if (k < NBITS - 1) check("parity_bit", tx, ^cur_b);
      else begin
        check("stop_bit", tx, 1);
        check("rx_byte", rx, cur_b);
        mon_act = 1'b0;
      end
    end
  end

  task automatic drain();
    int t = 0;
    while ((exp_byte.size() != 0 || mon_act || busy !== 1'b0) && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", t < 20000, 1);
    repeat (4) @(negedge clk);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    int e0, e1, e2, peak, t, f0, s0, lows;
    repeat (3) @(negedge clk);
    check("rst_tx", tx, 1);
    check("rst_count", count, 0);
    check("rst_full", full, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    reset = 1'b1;
    @(negedge clk);
    model_clear();
    mon_en = 1'b1;
    chk_en = 1'b1;

    // single byte, latency and busy fall
    push(8'h55, e0);
    gap(1);
    while (cyc < e0 + FRAME) @(negedge clk);
    check("busy_before_end", busy, 1);
    @(negedge clk);
    check("busy_fall", busy, 0);
    drain();

    // back-to-back with a simultaneous push/pop at count=1
    push(8'hA3, e1);
    push(8'h0F, e2);
    gap(1);
    check("pushpop_count", count, 1);
    peak = 0;
    t = 0;
    while (busy === 1'b1 && t < 2000) begin
      if (count > peak) peak = count;
      @(negedge clk);
      t++;
    end
    check("b2b_peak_count", peak, 1);
    drain();

    // overflow: one byte in flight, then five pushes into four free slots
    f0 = frames_seen;
    push(8'h11, e0);
    gap(5);
    push(8'h22, e0); push(8'h33, e0); push(8'h44, e0); push(8'h66, e0); push(8'h77, e0);
    gap(1);
    check("ovf_full", full, 1);
    check("ovf_flag", overflow, 1);
    check("ovf_count", count, 4);
    drain();
    check("ovf_frames", frames_seen - f0, 5);

    // randomized traffic
    repeat (25) begin
      push(8'($urandom), e0);
      if ($urandom_range(0, 3) == 0) gap($urandom_range(100, 300));
      else if ($urandom_range(0, 2) != 0) gap($urandom_range(1, 20));
    end
    gap(1);
    drain();

    // reset asserted during data bit 3
    push(8'hC6, e0);
    push(8'h3C, e1);
    push(8'h81, e2);
    gap(1);
    s0 = e0 + 1;
    while (cyc < s0 + 4 * DIV + DIV / 2) @(negedge clk);
    mon_en = 1'b0;
    chk_en = 1'b0;
    reset = 1'b0;
    #1;
    check("midrst_tx", tx, 1);
    check("midrst_count", count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_overflow", overflow, 0);
    check("midrst_full", full, 0);
    @(negedge clk);
    reset = 1'b1;
    model_clear();
    mon_act = 1'b0;
    mon_en = 1'b1;
    chk_en = 1'b1;
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx !== 1'b1) lows++;
    end
    check("post_rst_idle", lows, 0);

    chk_en = 1'b0;
    mon_en = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo.md
Name: uart_tx_fifo

Overview:
- UART transmit back-end behind the memory-mapped device block.
- Device-side writes push bytes into a small FIFO; a baud-rate serializer drains the FIFO onto the `tx` pin as 8N1 frames.
- Gives CPU stores a burst buffer, so software does not have to poll the line for every byte.

Parameters:
- CLK_FREQ, 70000000, system clock frequency in Hz.
- BAUD, 9600, line rate in bit/s.
  - DIV = CLK_FREQ / BAUD, integer-truncated, is the number of clock cycles per bit.
  - DIV must be ≥ 2.
- DEPTH, 8, FIFO depth in bytes. Must be a power of two and ≥ 2.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- wr_en  in  1  push request, sampled on the rising edge of clk.
- wr_data  in  8  byte to push.
- full  out  1  FIFO holds DEPTH entries.
- count  out  $clog2(DEPTH+1)  number of FIFO entries.
- overflow  out  1  sticky flag: a push was dropped.
- busy  out  1  high when the FSM is not IDLE or count ≠ 0.
- tx  out  1  serial line, registered output, idles high.

Behaviour:
- Reset (reset=0, asynchronous):
  - FIFO pointers and count = 0; full = 0, overflow = 0, busy = 0.
  - tx = 1; FSM = IDLE; baud counter and bit index = 0.
  - A reset asserted mid-frame aborts the frame immediately: tx returns to 1 and the FIFO contents are discarded.
- FIFO:
  - A push is accepted when wr_en=1 and full=0. wr_data is stored and count increments on the same edge.
  - wr_en=1 while full=1 drops the byte and sets overflow=1. Only reset clears overflow.
  - full is evaluated before any pop on the same edge, so a push while full is dropped even if a pop occurs on that edge.
  - Simultaneous accepted push and pop leaves count unchanged.
  - Read and write pointers wrap modulo DEPTH.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1. If count≠0, pop the head byte into the shift register, clear the baud counter, go to START, and drive tx=0 on that edge.
  - START: tx=0 for DIV cycles, then go to DATA with bit index 0.
  - DATA: tx = shift[0] (LSB first) for DIV cycles per bit. Shift right after each bit. After 8 bits go to STOP.
  - STOP: tx=1 for DIV cycles, then go to IDLE.
- Baud counter: counts 0..DIV-1. The state or bit advances on the edge where counter == DIV-1, and the counter wraps to 0.
- Latency and frame timing:
  - A push accepted at edge E0 into an empty FIFO with the FSM in IDLE makes tx fall at edge E0+1.
  - One frame lasts 10·DIV cycles.
  - Back-to-back frames have exactly 1 IDLE cycle (tx=1) between the end of STOP and the next start bit.
- busy falls on the edge the FSM enters IDLE with count=0.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - A PARITY state is inserted between DATA and STOP.
  - tx = XOR of the 8 data bits (even parity) for DIV cycles.
  - Frame length = 11·DIV cycles.
- Undefined:
  - No PARITY state; 8N1 frames of 10·DIV cycles.
  - No parity logic is synthesized.

Test Plan:
- Bench parameters: CLK_FREQ=16, BAUD=1, DIV=16, DEPTH=4.
- Single byte: push 0x55 at edge E0 → tx=0 over E0+1..E0+16; bits 1,0,1,0,1,0,1,0 at 16 cycles each; tx=1 for 16 cycles; busy=0 at E0+161.
- Back-to-back: push 0xA3 then 0x0F on consecutive cycles → two frames decode to 0xA3 and 0x0F, separated by exactly one idle cycle; count peaks at 1.
- Overflow: with the FSM held busy, push 5 bytes while 4 slots are free → full=1, the 5th byte is dropped, overflow=1, and only 4 frames are emitted.
- Simultaneous push/pop at count=1 → count stays 1 and no data is corrupted.
- Mid-frame reset: drive reset=0 during DATA bit 3 → tx=1, count=0, busy=0, overflow=0 immediately; after release the line stays idle.
- With UART_TX_PARITY_EN, push 0x07 → parity bit = 1, stop bit follows, frame is 176 cycles.
